// File: rtl/alu_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : alu_sequencer_if
// Brief   : Command, response and datapath-control bundle for alu_sequencer.
// Revision: 1.0 - initial release
// ============================================================================
interface alu_sequencer_if #(
   parameter int WIDTH = 4,
   parameter int SHIFT = 2,
   parameter int OPW   = 2,
   parameter int CNT_W = 8
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [OPW-1:0]   cmd_op;
   logic [SHIFT-1:0] cmd_shamt;
   logic [WIDTH-1:0] cmd_x;
   logic [WIDTH-1:0] cmd_y;
   logic             cmd_chain;

   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_result;
   logic             rsp_zero;

   logic             dp_load_x;
   logic             dp_load_y;
   logic [WIDTH-1:0] dp_data;
   logic [OPW-1:0]   dp_operation;
   logic [SHIFT-1:0] dp_shamt;
   logic [WIDTH-1:0] dp_result;
   logic             dp_zero;

   logic             busy;
   logic [CNT_W-1:0] op_count;

   // Sequencer side.
   modport master (
      input  cmd_valid, cmd_op, cmd_shamt, cmd_x, cmd_y, cmd_chain,
      input  rsp_ready, dp_result, dp_zero,
      output cmd_ready, rsp_valid, rsp_result, rsp_zero,
      output dp_load_x, dp_load_y, dp_data, dp_operation, dp_shamt,
      output busy, op_count
   );

   // Command source, response sink and ALU datapath side.
   modport slave (
      output cmd_valid, cmd_op, cmd_shamt, cmd_x, cmd_y, cmd_chain,
      output rsp_ready, dp_result, dp_zero,
      input  cmd_ready, rsp_valid, rsp_result, rsp_zero,
      input  dp_load_x, dp_load_y, dp_data, dp_operation, dp_shamt,
      input  busy, op_count
   );
endinterface : alu_sequencer_if
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : alu_sequencer
// Brief   : Command-driven controller loading X/Y over a shared bus, waiting
//           for the ALU to settle and returning result/zero on a response port.
//           Optional macro ALU_SEQ_CHAIN_EN: cmd_chain loads X from the last
//           response result instead of cmd_x.
// Revision: 1.0 - initial release
// ============================================================================
module alu_sequencer #(
   parameter int WIDTH     = 4,
   parameter int SHIFT     = 2,
   parameter int OPW       = 2,
   parameter int EXEC_WAIT = 1,
   parameter int CNT_W     = 8
) (
   input  logic            clock,
   input  logic            reset,
   alu_sequencer_if.master bus
);

   localparam int EW_EFF = (EXEC_WAIT < 1) ? 1 : EXEC_WAIT;
   localparam int WAIT_W = (EW_EFF > 1) ? $clog2(EW_EFF) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(EW_EFF - 1);
   localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD_X = 3'd1,
      S_LOAD_Y = 3'd2,
      S_EXEC   = 3'd3,
      S_RESP   = 3'd4
   } state_t;

   state_t             state_q,  state_d;
   logic [WAIT_W-1:0]  wait_q,   wait_d;
   logic [OPW-1:0]     op_q,     op_d;
   logic [SHIFT-1:0]   shamt_q,  shamt_d;
   logic [WIDTH-1:0]   x_q,      x_d;
   logic [WIDTH-1:0]   y_q,      y_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               zero_q,   zero_d;
   logic [CNT_W-1:0]   count_q,  count_d;

   logic               cmd_ready_q, cmd_ready_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic               load_x_q,    load_x_d;
   logic               load_y_q,    load_y_d;
   logic [WIDTH-1:0]   data_q,      data_d;
   logic               busy_q,      busy_d;

   logic               w_chain;

`ifdef ALU_SEQ_CHAIN_EN
   assign w_chain = bus.cmd_chain;
`else
   logic unused_chain;
   assign unused_chain = bus.cmd_chain;
   assign w_chain      = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      wait_d   = wait_q;
      op_d     = op_q;
      shamt_d  = shamt_q;
      x_d      = x_q;
      y_d      = y_q;
      result_d = result_q;
      zero_d   = zero_q;
      count_d  = count_q;

      case (state_q)
         S_IDLE: begin
            if (bus.cmd_valid) begin
               op_d    = bus.cmd_op;
               shamt_d = bus.cmd_shamt;
               // A chained command feeds the previous result back as X.
               x_d     = w_chain ? result_q : bus.cmd_x;
               y_d     = bus.cmd_y;
               state_d = S_LOAD_X;
            end
         end
         S_LOAD_X: state_d = S_LOAD_Y;
         S_LOAD_Y: begin
            wait_d  = '0;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            if (wait_q == WAIT_LAST) begin
               result_d = bus.dp_result;
               zero_d   = bus.dp_zero;
               state_d  = S_RESP;
            end else begin
               wait_d = wait_q + WAIT_ONE;
            end
         end
         S_RESP: begin
            if (bus.rsp_ready) begin
               count_d = count_q + CNT_ONE;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Outputs are decoded from the next state so they come straight from flops.
      cmd_ready_d = (state_d == S_IDLE);
      busy_d      = (state_d != S_IDLE);
      rsp_valid_d = (state_d == S_RESP);
      load_x_d    = (state_d == S_LOAD_X);
      load_y_d    = (state_d == S_LOAD_Y);
      if (state_d == S_LOAD_X) begin
         data_d = x_d;
      end else if (state_d == S_LOAD_Y) begin
         data_d = y_d;
      end else begin
         data_d = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_IDLE;
         wait_q      <= '0;
         op_q        <= '0;
         shamt_q     <= '0;
         x_q         <= '0;
         y_q         <= '0;
         result_q    <= '0;
         zero_q      <= 1'b0;
         count_q     <= '0;
         cmd_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         load_x_q    <= 1'b0;
         load_y_q    <= 1'b0;
         data_q      <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_q      <= wait_d;
         op_q        <= op_d;
         shamt_q     <= shamt_d;
         x_q         <= x_d;
         y_q         <= y_d;
         result_q    <= result_d;
         zero_q      <= zero_d;
         count_q     <= count_d;
         cmd_ready_q <= cmd_ready_d;
         rsp_valid_q <= rsp_valid_d;
         load_x_q    <= load_x_d;
         load_y_q    <= load_y_d;
         data_q      <= data_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.cmd_ready    = cmd_ready_q;
   assign bus.rsp_valid    = rsp_valid_q;
   assign bus.rsp_result   = result_q;
   assign bus.rsp_zero     = zero_q;
   assign bus.dp_load_x    = load_x_q;
   assign bus.dp_load_y    = load_y_q;
   assign bus.dp_data      = data_q;
   // Operation/shamt stay on the latched command, holding through IDLE.
   assign bus.dp_operation = op_q;
   assign bus.dp_shamt     = shamt_q;
   assign bus.busy         = busy_q;
   assign bus.op_count     = count_q;

endmodule : alu_sequencer
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_sequencer
// Brief   : Two sequencer instances (EXEC_WAIT 1/3, CNT_W 2/8) with an ALU stub,
//           transaction-level reference model, directed pins and random traffic.
// Revision: 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic [1:0] cmd_op;
   logic [1:0] cmd_shamt;
   logic [3:0] cmd_x;
   logic [3:0] cmd_y;
   logic       cmd_chain;
   logic       rsp_ready;

   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   logic       cmp_en = 1'b0;
   logic       pin_phase = 1'b0;
   logic       rst_pin = 1'b0;
   int         t_cmd = 0;
   logic [3:0] pin_x, pin_y, pin_res;
   logic       pin_zero;
   int         pin_cnt;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int inst, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s inst%0d actual=%0d expected=%0d cycle=%0d", nm, inst, act, expv, cyc);
      end
   endtask

   // ALU behaviour assumed by the bench stub; the sequencer treats the opcode as opaque.
   function automatic logic [3:0] alu_f(input logic [1:0] op, input logic [3:0] x,
                                        input logic [3:0] y, input logic [1:0] sh);
      logic [3:0] r;
      case (op)
         2'd0:    r = x + y;
         2'd1:    r = x - y;
         2'd2:    r = x & y;
         default: r = (x << sh) ^ y;
      endcase
      return r;
   endfunction

   for (genvar gi = 0; gi < 2; gi++) begin : g_inst
      localparam int EW      = (gi == 0) ? 1 : 3;
      localparam int CW      = (gi == 0) ? 2 : 8;
      localparam int RESP_K  = 3 + EW;
      localparam int PIN_LAT = (gi == 0) ? 4 : 6;

      alu_sequencer_if #(.WIDTH(4), .SHIFT(2), .OPW(2), .CNT_W(CW)) bus ();

      logic [3:0] st_x, st_y, st_f;
      int         st_cnt;

      assign bus.cmd_valid = cmd_valid;
      assign bus.cmd_op    = cmd_op;
      assign bus.cmd_shamt = cmd_shamt;
      assign bus.cmd_x     = cmd_x;
      assign bus.cmd_y     = cmd_y;
      assign bus.cmd_chain = cmd_chain;
      assign bus.rsp_ready = rsp_ready;

      alu_sequencer #(.WIDTH(4), .SHIFT(2), .OPW(2), .EXEC_WAIT(EW), .CNT_W(CW)) u_dut (
         .clock (clk),
         .reset (rst),
         .bus   (bus)
      );

      // ALU stub: X/Y registers, output only settles EW-1 cycles after the Y load.
      always @(posedge clk) begin
         if (rst) begin
            st_x   <= 4'd0;
            st_y   <= 4'd0;
            st_cnt <= 0;
         end else begin
            if (bus.dp_load_x) st_x <= bus.dp_data;
            if (bus.dp_load_y) begin
               st_y   <= bus.dp_data;
               st_cnt <= 0;
            end else if (st_cnt < 100) begin
               st_cnt <= st_cnt + 1;
            end
         end
      end
      assign st_f          = alu_f(bus.dp_operation, st_x, st_y, bus.dp_shamt);
      assign bus.dp_result = (st_cnt >= EW - 1) ? st_f : (st_f ^ 4'hA);
      assign bus.dp_zero   = (bus.dp_result == 4'd0);

      // Reference model: k counts cycles since the accepting cycle.
      bit         m_active = 1'b0;
      int         m_k = 0;
      logic [1:0] m_op = '0, m_sh = '0;
      logic [3:0] m_x = '0, m_y = '0, m_res = '0;
      logic       m_zero = 1'b0;
      int         m_cnt = 0;

      always @(posedge clk) begin
         if (rst) begin
            m_active = 1'b0; m_k = 0; m_op = '0; m_sh = '0;
            m_x = '0; m_y = '0; m_res = '0; m_zero = 1'b0; m_cnt = 0;
         end else if (!m_active) begin
            if (cmd_valid) begin
               m_active = 1'b1;
               m_k  = 1;
               m_op = cmd_op;
               m_sh = cmd_shamt;
               m_y  = cmd_y;
               m_x  = cmd_x;
`ifdef ALU_SEQ_CHAIN_EN
               if (cmd_chain) m_x = m_res;
`endif
            end
         end else if (m_k >= RESP_K) begin
            if (rsp_ready) begin
               m_active = 1'b0;
               m_cnt    = (m_cnt + 1) % (1 << CW);
            end
         end else begin
            m_k++;
            if (m_k == RESP_K) begin
               m_res  = alu_f(m_op, m_x, m_y, m_sh);
               m_zero = (m_res == 4'd0);
            end
         end
      end

      always @(negedge clk) begin
         if (cmp_en) begin
            logic       e_lx, e_ly;
            logic [3:0] e_data;
            e_lx   = m_active && (m_k == 1);
            e_ly   = m_active && (m_k == 2);
            e_data = e_lx ? m_x : (e_ly ? m_y : 4'd0);
            chk("busy",       gi, int'(bus.busy),         int'(m_active));
            chk("cmd_ready",  gi, int'(bus.cmd_ready),    int'(!m_active));
            chk("rsp_valid",  gi, int'(bus.rsp_valid),    int'(m_active && m_k >= RESP_K));
            chk("rsp_result", gi, int'(bus.rsp_result),   int'(m_res));
            chk("rsp_zero",   gi, int'(bus.rsp_zero),     int'(m_zero));
            chk("load_x",     gi, int'(bus.dp_load_x),    int'(e_lx));
            chk("load_y",     gi, int'(bus.dp_load_y),    int'(e_ly));
            chk("dp_data",    gi, int'(bus.dp_data),      int'(e_data));
            chk("dp_op",      gi, int'(bus.dp_operation), int'(m_op));
            chk("dp_shamt",   gi, int'(bus.dp_shamt),     int'(m_sh));
            chk("op_count",   gi, int'(bus.op_count),     m_cnt);
         end
         if (pin_phase) begin
            if (cyc == t_cmd + 1) begin
               chk("pin_ldx",      gi, int'(bus.dp_load_x), 1);
               chk("pin_ldx_data", gi, int'(bus.dp_data),   int'(pin_x));
            end
            if (cyc == t_cmd + 2) begin
               chk("pin_ldy",      gi, int'(bus.dp_load_y), 1);
               chk("pin_ldy_data", gi, int'(bus.dp_data),   int'(pin_y));
            end
            if (cyc == t_cmd + PIN_LAT - 1)
               chk("pin_rsp_early", gi, int'(bus.rsp_valid), 0);
            if (cyc == t_cmd + PIN_LAT) begin
               chk("pin_rsp_valid",  gi, int'(bus.rsp_valid),  1);
               chk("pin_rsp_result", gi, int'(bus.rsp_result), int'(pin_res));
               chk("pin_rsp_zero",   gi, int'(bus.rsp_zero),   int'(pin_zero));
            end
            if (cyc == t_cmd + 24)
               chk("pin_count", gi, int'(bus.op_count), (gi == 0) ? (pin_cnt % 4) : pin_cnt);
         end
         if (rst_pin) begin
            chk("rst_busy",      gi, int'(bus.busy),      0);
            chk("rst_cmd_ready", gi, int'(bus.cmd_ready), 1);
            chk("rst_rsp_valid", gi, int'(bus.rsp_valid), 0);
            chk("rst_op_count",  gi, int'(bus.op_count),  0);
            chk("rst_loads",     gi, int'(bus.dp_load_x) + int'(bus.dp_load_y), 0);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pin_op(input logic [3:0] x, input logic [3:0] y, input logic [1:0] op,
                         input logic [1:0] sh, input logic chain, input logic [3:0] ex_x,
                         input logic [3:0] res, input logic z, input int cnt, input int hold);
      cmd_valid = 1'b1;
      cmd_x = x; cmd_y = y; cmd_op = op; cmd_shamt = sh; cmd_chain = chain;
      pin_x = ex_x; pin_y = y; pin_res = res; pin_zero = z; pin_cnt = cnt;
      rsp_ready = (hold == 0);
      t_cmd = cyc;
      pin_phase = 1'b1;
      step();
      cmd_valid = 1'b0;
      cmd_chain = 1'b0;
      for (int i = 0; i < 25; i++) begin
         if (hold != 0 && cyc == t_cmd + hold) rsp_ready = 1'b1;
         step();
      end
      pin_phase = 1'b0;
      rsp_ready = 1'b1;
   endtask

   initial begin
      int lowrun;
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_shamt = '0;
      cmd_x = '0; cmd_y = '0; cmd_chain = 1'b0; rsp_ready = 1'b1;
      step(); step(); step();
      cmp_en = 1'b1;
      rst = 1'b0;
      step();

      pin_op(4'd3, 4'd5, 2'd0, 2'd0, 1'b0, 4'd3, 4'd8,  1'b0, 1, 0);
      pin_op(4'd5, 4'd5, 2'd1, 2'd0, 1'b0, 4'd5, 4'd0,  1'b1, 2, 0);
      pin_op(4'd3, 4'd1, 2'd3, 2'd2, 1'b0, 4'd3, 4'd13, 1'b0, 3, 14);
      pin_op(4'd4, 4'd2, 2'd0, 2'd0, 1'b0, 4'd4, 4'd6,  1'b0, 4, 0);
`ifdef ALU_SEQ_CHAIN_EN
      pin_op(4'd9, 4'd2, 2'd0, 2'd0, 1'b1, 4'd6, 4'd8,  1'b0, 5, 0);
`else
      pin_op(4'd9, 4'd2, 2'd0, 2'd0, 1'b1, 4'd9, 4'd11, 1'b0, 5, 0);
`endif

      // Reset pulse while the slow instance is mid-EXEC and the fast one waits in RESP.
      rsp_ready = 1'b0;
      cmd_valid = 1'b1; cmd_x = 4'd1; cmd_y = 4'd1; cmd_op = 2'd0; cmd_shamt = 2'd0;
      t_cmd = cyc;
      step();
      cmd_valid = 1'b0;
      while (cyc < t_cmd + 4) step();
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
      rst_pin = 1'b1;
      step();
      rst_pin = 1'b0;
      rsp_ready = 1'b1;

      lowrun = 0;
      for (int n = 0; n < 3000; n++) begin
         cmd_valid = ($urandom_range(0, 1) == 1);
         cmd_op    = 2'($urandom_range(0, 3));
         cmd_shamt = 2'($urandom_range(0, 3));
         cmd_x     = 4'($urandom_range(0, 15));
         cmd_y     = 4'($urandom_range(0, 15));
         cmd_chain = ($urandom_range(0, 2) == 0);
         if (lowrun > 0) begin
            rsp_ready = 1'b0;
            lowrun--;
         end else begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 40) == 0) lowrun = int'($urandom_range(5, 15));
         end
         rst = ($urandom_range(0, 249) == 0);
         step();
      end
      rst = 1'b0;
      cmd_valid = 1'b0;
      step(); step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_alu_sequencer
`default_nettype wire
